vga_sync_gen: RTL and testbench
===============================

Name: vga_sync_gen

Overview:
- Timing generator for the 640x480 VGA monitor path; it produces the pixel coordinates consumed by the text/font writer and the HSYNC/VSYNC pins.
- Divides the system clock into a pixel tick and runs horizontal/vertical counters.
- Provides a sync/blank delay line so that pin timing matches the latency of the writer → font ROM → RGB path.

Parameters:
- CLK_DIV, 2, system clocks per pixel (50 MHz → 25 MHz); legal range ≥1
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch
- H_SYNC, 96, horizontal sync width
- H_BACK, 48, horizontal back porch
- V_DISPLAY, 480, visible lines
- V_FRONT, 10, vertical front porch
- V_SYNC, 2, vertical sync width
- V_BACK, 33, vertical back porch
- SYNC_DELAY, 2, pixel ticks by which hsync/vsync/video_on lag pix_x/pix_y; legal range 0..7

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- p_tick  out  1  one-clk pulse per pixel
- pix_x  out  10  horizontal count 0..H_TOTAL-1
- pix_y  out  10  vertical count 0..V_TOTAL-1
- video_on  out  1  visible-area flag, delayed by SYNC_DELAY ticks
- hsync  out  1  active-low, delayed by SYNC_DELAY ticks
- vsync  out  1  active-low, delayed by SYNC_DELAY ticks
- frame_start  out  1  one-clk pulse when counters wrap to (0,0)

Behaviour:
- Derived values: H_TOTAL = sum of the four H parameters (800); V_TOTAL = sum of the four V parameters (525).
- Clock divider: div_cnt counts 0..CLK_DIV-1. p_tick = (div_cnt == CLK_DIV-1), combinational from the register. With CLK_DIV=1, p_tick is held at 1.
- Counters advance only in a clock where p_tick=1:
  - h_cnt → 0 when h_cnt == H_TOTAL-1, otherwise h_cnt+1.
  - v_cnt increments only on h wrap; v_cnt → 0 when v_cnt == V_TOTAL-1.
- pix_x = h_cnt and pix_y = v_cnt, driven directly from the registers.
- frame_start is registered. It is 1 for exactly the one clk after the (H_TOTAL-1, V_TOTAL-1) → (0,0) transition.
- Raw (undelayed) signals, all active-low where noted:
  - raw_h low iff H_DISPLAY+H_FRONT ≤ h_cnt ≤ H_DISPLAY+H_FRONT+H_SYNC-1, i.e. 656..751.
  - raw_v low iff V_DISPLAY+V_FRONT ≤ v_cnt ≤ V_DISPLAY+V_FRONT+V_SYNC-1, i.e. 490..491.
  - raw_on = (h_cnt < H_DISPLAY) && (v_cnt < V_DISPLAY).
- Delay line: SYNC_DELAY-stage shift register of {raw_h, raw_v, raw_on}, shifting only on p_tick.
  - Outputs are taken from the last stage.
  - With SYNC_DELAY=0, the outputs are raw_* passed through an output register that also updates on p_tick.
- Reset (asynchronous, any time including mid-frame):
  - div_cnt, h_cnt, v_cnt = 0
  - hsync = vsync = 1
  - video_on = 0, frame_start = 0
  - every delay stage loaded with {1,1,0}
- After reset release: first p_tick at clk CLK_DIV; the counting sequence restarts from (0,0). No frame_start pulse is issued for this initial (0,0) start.
- Counters never exceed H_TOTAL-1 / V_TOTAL-1; no illegal intermediate values.

Optional Feature:
- Macro: VGA_SYNC_SEC_TICK_EN.
- Defined:
  - Adds output port sec_tick (1 bit).
  - A 6-bit frame counter increments on each frame_start and wraps 59 → 0.
  - sec_tick pulses for one clk coincident with the frame_start that wraps the counter. This is the 1 Hz base for the MM:SS timer digits.
  - Reset clears the counter and sec_tick.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Decomposition:
- Package vga_timing_pkg holds:
  - default 640x480 porch/sync constants
  - H_TOTAL/V_TOTAL derivations
  - the 10-bit coordinate width constant
- One sub-module, vga_sync_delay: parameterised shift register with enable, width 3, depth SYNC_DELAY, reset value {1,1,0}.

Test Plan:
- Reset, run one frame (840000 clk): p_tick every 2nd clk; pix_x wraps 799 → 0; pix_y wraps 524 → 0; exactly one frame_start.
- SYNC_DELAY=0: hsync low for exactly 96 consecutive ticks starting at the tick after pix_x=655 → 656; vsync low for lines 490–491 only (1600 ticks).
- SYNC_DELAY=2: video_on rises 2 ticks after pix_x=0, pix_y=0 and falls 2 ticks after pix_x reaches 640; 307200 active ticks per frame.
- Assert reset at pix_x=300, pix_y=200, then release: outputs return to their reset values immediately (asynchronously); counting restarts at (0,0); hsync stays high until pix_x=656.
- CLK_DIV=1: p_tick constant 1; one line = 800 clk; frame_start period = 420000 clk.
- With VGA_SYNC_SEC_TICK_EN: sec_tick on the 60th frame_start and every 60th thereafter; never on any other frame_start.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared 640x480 timing constants, coordinate width and sync-bit layout for the VGA path.
package vga_timing_pkg;

  localparam int COORD_W = 10;

  localparam int H_DISPLAY_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int V_DISPLAY_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;

  function automatic int total4(input int a, input int b, input int c, input int d);
    return a + b + c + d;
  endfunction

  localparam int H_TOTAL_DEF = total4(H_DISPLAY_DEF, H_FRONT_DEF, H_SYNC_DEF, H_BACK_DEF);
  localparam int V_TOTAL_DEF = total4(V_DISPLAY_DEF, V_FRONT_DEF, V_SYNC_DEF, V_BACK_DEF);

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic video_on;
  } sync_bits_t;

  // Idle pin state: both syncs inactive (high), blanked.
  localparam sync_bits_t SYNC_IDLE = 3'b110;

endpackage

// File: rtl/vga_sync_gen_if.sv
// Timing bundle from vga_sync_gen to its consumers; sec_tick exists only with VGA_SYNC_SEC_TICK_EN.
interface vga_sync_gen_if;
  import vga_timing_pkg::*;

  logic               p_tick;
  logic [COORD_W-1:0] pix_x;
  logic [COORD_W-1:0] pix_y;
  logic               video_on;
  logic               hsync;
  logic               vsync;
  logic               frame_start;
`ifdef VGA_SYNC_SEC_TICK_EN
  logic               sec_tick;
`endif

  modport master (
    output p_tick, pix_x, pix_y, video_on, hsync, vsync, frame_start
`ifdef VGA_SYNC_SEC_TICK_EN
    , output sec_tick
`endif
  );

  modport slave (
    input p_tick, pix_x, pix_y, video_on, hsync, vsync, frame_start
`ifdef VGA_SYNC_SEC_TICK_EN
    , input sec_tick
`endif
  );

endinterface

// File: rtl/vga_sync_delay.sv
// Enable-gated shift register aligning sync/blank pins with the pixel datapath latency.
module vga_sync_delay #(
  parameter int               WIDTH   = 3,
  parameter int               DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  // Zero depth still keeps one output register so the pins stay registered.
  localparam int STAGES = (DEPTH == 0) ? 1 : DEPTH;

  logic [WIDTH-1:0] r_stage [STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        r_stage[i] <= RST_VAL;
      end
    end else if (i_en) begin
      r_stage[0] <= i_d;
      for (int i = 1; i < STAGES; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_q = r_stage[STAGES-1];

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel-tick divider, h/v counters, delayed sync/blank pins.
// Optional 1 Hz sec_tick (frame counter modulo 60) enabled by defining VGA_SYNC_SEC_TICK_EN.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV    = 2,
  parameter int H_DISPLAY  = H_DISPLAY_DEF,
  parameter int H_FRONT    = H_FRONT_DEF,
  parameter int H_SYNC     = H_SYNC_DEF,
  parameter int H_BACK     = H_BACK_DEF,
  parameter int V_DISPLAY  = V_DISPLAY_DEF,
  parameter int V_FRONT    = V_FRONT_DEF,
  parameter int V_SYNC     = V_SYNC_DEF,
  parameter int V_BACK     = V_BACK_DEF,
  parameter int SYNC_DELAY = 2
) (
  input  logic           clk,
  input  logic           reset,
  vga_sync_gen_if.master o_vga
);

  localparam int H_TOTAL = total4(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = total4(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0]   DIV_ONE   = DIV_W'(1);
  localparam logic [COORD_W-1:0] COORD_ONE = COORD_W'(1);
  localparam logic [COORD_W-1:0] H_LAST    = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST    = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_VIS     = COORD_W'(H_DISPLAY);
  localparam logic [COORD_W-1:0] V_VIS     = COORD_W'(V_DISPLAY);
  localparam logic [COORD_W-1:0] HS_START  = COORD_W'(H_DISPLAY + H_FRONT);
  localparam logic [COORD_W-1:0] HS_END    = COORD_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [COORD_W-1:0] VS_START  = COORD_W'(V_DISPLAY + V_FRONT);
  localparam logic [COORD_W-1:0] VS_END    = COORD_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic [DIV_W-1:0]   r_div;
  logic [COORD_W-1:0] r_h;
  logic [COORD_W-1:0] r_v;
  logic               r_frame_start;
  logic [COORD_W-1:0] w_h_next;
  logic [COORD_W-1:0] w_v_next;
  logic               w_p_tick;
  logic               w_h_last;
  logic               w_v_last;
  logic               w_frame_wrap;
  sync_bits_t         w_raw;
  sync_bits_t         w_sync;

  // With CLK_DIV=1 the divider sits at 0 == DIV_LAST, holding p_tick high.
  assign w_p_tick     = (r_div == DIV_LAST);
  assign w_h_last     = (r_h == H_LAST);
  assign w_v_last     = (r_v == V_LAST);
  assign w_frame_wrap = w_p_tick && w_h_last && w_v_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div <= '0;
    end else if (w_p_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DIV_ONE;
    end
  end

  always_comb begin
    w_h_next = r_h;
    w_v_next = r_v;
    if (w_p_tick) begin
      if (w_h_last) begin
        w_h_next = '0;
        if (w_v_last) begin
          w_v_next = '0;
        end else begin
          w_v_next = r_v + COORD_ONE;
        end
      end else begin
        w_h_next = r_h + COORD_ONE;
      end
    end else begin
      w_h_next = r_h;
      w_v_next = r_v;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_h           <= '0;
      r_v           <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_h           <= w_h_next;
      r_v           <= w_v_next;
      r_frame_start <= w_frame_wrap;
    end
  end

  always_comb begin
    w_raw          = SYNC_IDLE;
    w_raw.hsync    = ~((r_h >= HS_START) && (r_h <= HS_END));
    w_raw.vsync    = ~((r_v >= VS_START) && (r_v <= VS_END));
    w_raw.video_on = (r_h < H_VIS) && (r_v < V_VIS);
  end

  vga_sync_delay #(
    .WIDTH   (3),
    .DEPTH   (SYNC_DELAY),
    .RST_VAL (SYNC_IDLE)
  ) u_sync_delay (
    .clk  (clk),
    .rst  (reset),
    .i_en (w_p_tick),
    .i_d  (w_raw),
    .o_q  (w_sync)
  );

`ifdef VGA_SYNC_SEC_TICK_EN
  logic [5:0] r_frame_cnt;
  logic       r_sec_tick;

  // sec_tick is registered alongside frame_start so the two pulses coincide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_frame_cnt <= 6'd0;
      r_sec_tick  <= 1'b0;
    end else if (w_frame_wrap) begin
      if (r_frame_cnt == 6'd59) begin
        r_frame_cnt <= 6'd0;
        r_sec_tick  <= 1'b1;
      end else begin
        r_frame_cnt <= r_frame_cnt + 6'd1;
        r_sec_tick  <= 1'b0;
      end
    end else begin
      r_sec_tick <= 1'b0;
    end
  end

  assign o_vga.sec_tick = r_sec_tick;
`endif

  assign o_vga.p_tick      = w_p_tick;
  assign o_vga.pix_x       = r_h;
  assign o_vga.pix_y       = r_v;
  assign o_vga.hsync       = w_sync.hsync;
  assign o_vga.vsync       = w_sync.vsync;
  assign o_vga.video_on    = w_sync.video_on;
  assign o_vga.frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen on a reduced 15x8 raster: CLK_DIV=2/SYNC_DELAY=2 and CLK_DIV=1/SYNC_DELAY=0.
module tb_vga_sync_gen;

  localparam int HD = 8, HF = 2, HS = 3, HB = 2, HT = 15;
  localparam int VD = 4, VF = 1, VS = 2, VB = 1, VT = 8;
  localparam int FT  = HT * VT;
  localparam int NA1 = 61 * FT + 5;
  localparam int NB1 = 2 * NA1;
  localparam int NA2 = 300;
  localparam int NB2 = 600;

  typedef struct {
    int          tick;
    logic [23:0] v;
    logic        fs_next;
    logic        sec_now;
    logic        sec_next;
  } item_t;

  typedef struct {
    int          tick;
    logic [23:0] v;
  } dir_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  item_t qa[$];
  item_t qb[$];
  dir_t  dq[$];

  int n_pass  = 0;
  int n_total = 0;

  vga_sync_gen_if ifa ();
  vga_sync_gen_if ifb ();

  vga_sync_gen #(
    .CLK_DIV(2), .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .SYNC_DELAY(2)
  ) dut_a (.clk(clk), .reset(reset), .o_vga(ifa));

  vga_sync_gen #(
    .CLK_DIV(1), .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .SYNC_DELAY(0)
  ) dut_b (.clk(clk), .reset(reset), .o_vga(ifb));

  always #5 clk = ~clk;

  function automatic logic [23:0] pack(input int x, input int y, input bit hs, input bit vs,
                                       input bit on, input bit fs);
    return {10'(x), 10'(y), hs, vs, on, fs};
  endfunction

  // Expected outputs at the k-th pixel tick; pins reflect the pixel lag ticks earlier.
  function automatic item_t model(input int k, input int lag, input bit fast);
    item_t it;
    int    j, xj, yj;
    bit    hs, vs, on, fs;
    hs = 1'b1; vs = 1'b1; on = 1'b0;
    j = k - lag;
    if (j >= 0) begin
      xj = j % HT;
      yj = (j / HT) % VT;
      hs = !(xj >= HD + HF && xj < HD + HF + HS);
      vs = !(yj >= VD + VF && yj < VD + VF + VS);
      on = (xj < HD) && (yj < VD);
    end
    fs          = fast && (k > 0) && (k % FT == 0);
    it.tick     = k;
    it.v        = pack(k % HT, (k / HT) % VT, hs, vs, on, fs);
    it.fs_next  = ((k + 1) % FT == 0);
    it.sec_now  = fast && (k > 0) && (k % (60 * FT) == 0);
    it.sec_next = ((k + 1) % (60 * FT) == 0);
    return it;
  endfunction

  task automatic dir(input int t, input int x, input int y, input bit hs, input bit vs, input bit on);
    dir_t d;
    d.tick = t;
    d.v    = pack(x, y, hs, vs, on, 1'b0);
    dq.push_back(d);
  endtask

  task automatic load(input int na, input int nb);
    for (int k = 0; k < na; k++) qa.push_back(model(k, 2, 1'b0));
    for (int k = 1; k <= nb; k++) qb.push_back(model(k, 1, 1'b1));
    dir(0, 0, 0, 1, 1, 0);    dir(1, 1, 0, 1, 1, 0);
    dir(2, 2, 0, 1, 1, 1);    dir(9, 9, 0, 1, 1, 1);
    dir(10, 10, 0, 1, 1, 0);  dir(12, 12, 0, 0, 1, 0);
    dir(14, 14, 0, 0, 1, 0);  dir(15, 0, 1, 1, 1, 0);
    dir(77, 2, 5, 1, 0, 0);   dir(107, 2, 7, 1, 1, 0);
    dir(120, 0, 0, 1, 1, 0);  dir(122, 2, 0, 1, 1, 1);
  endtask

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s tick=%0d actual=%h required=%h", name, k, act, exp);
  endtask

  task automatic drain();
    for (int i = 0; i < 30000 && (qa.size() > 0 || qb.size() > 0); i++) @(negedge clk);
    if (qa.size() > 0 || qb.size() > 0) begin
      $display("FAIL drain_timeout actual=%0d/%0d pending required=0/0", qa.size(), qb.size());
      $fatal(1, "scoreboard did not drain");
    end
  endtask

  // Monitor: reset-value checks (async, on reset assertion and each clk in reset) and scoreboard pops.
  initial begin
    item_t it;
    dir_t  d;
    int    n_clk;
    bit    a_pend;
    int    a_tick;
    logic  a_fs_exp, a_sec_exp;
    n_clk = 0; a_pend = 1'b0; a_tick = 0; a_fs_exp = 1'b0; a_sec_exp = 1'b0;
    forever begin
      @(negedge clk or posedge reset);
      if (reset) begin
        #1;
        n_clk  = 0;
        a_pend = 1'b0;
        chk("rst_a", -1, {ifa.pix_x, ifa.pix_y, ifa.hsync, ifa.vsync, ifa.video_on, ifa.frame_start},
            pack(0, 0, 1, 1, 0, 0));
        chk("rst_b", -1, {ifb.pix_x, ifb.pix_y, ifb.hsync, ifb.vsync, ifb.video_on, ifb.frame_start},
            pack(0, 0, 1, 1, 0, 0));
        chk("rst_ptick_a", -1, ifa.p_tick, 1'b0);
        chk("rst_ptick_b", -1, ifb.p_tick, 1'b1);
`ifdef VGA_SYNC_SEC_TICK_EN
        chk("rst_sec", -1, {ifa.sec_tick, ifb.sec_tick}, 2'b00);
`endif
      end else begin
        n_clk++;
        chk("ptick_a", n_clk, ifa.p_tick, (n_clk % 2 == 1));
        chk("ptick_b", n_clk, ifb.p_tick, 1'b1);
        if (a_pend) begin
          chk("fs_a", a_tick, ifa.frame_start, a_fs_exp);
`ifdef VGA_SYNC_SEC_TICK_EN
          chk("sec_a", a_tick, ifa.sec_tick, a_sec_exp);
`endif
          a_pend = 1'b0;
        end
        if (ifa.p_tick && qa.size() > 0) begin
          it = qa.pop_front();
          chk("pix_a", it.tick, {ifa.pix_x, ifa.pix_y, ifa.hsync, ifa.vsync, ifa.video_on, ifa.frame_start}, it.v);
          a_pend    = 1'b1;
          a_tick    = it.tick;
          a_fs_exp  = it.fs_next;
          a_sec_exp = it.sec_next;
          if (dq.size() > 0 && dq[0].tick == it.tick) begin
            d = dq.pop_front();
            chk("dir_a", d.tick, {ifa.pix_x, ifa.pix_y, ifa.hsync, ifa.vsync, ifa.video_on, ifa.frame_start}, d.v);
          end
        end
        if (ifb.p_tick && qb.size() > 0) begin
          it = qb.pop_front();
          chk("pix_b", it.tick, {ifb.pix_x, ifb.pix_y, ifb.hsync, ifb.vsync, ifb.video_on, ifb.frame_start}, it.v);
`ifdef VGA_SYNC_SEC_TICK_EN
          chk("sec_b", it.tick, ifb.sec_tick, it.sec_now);
`endif
        end
      end
    end
  end

  // Stimulus: two runs from reset, the second after an asynchronous mid-frame reset.
  initial begin
    bit hit;
    repeat (3) @(negedge clk);
    load(NA1, NB1);
    @(negedge clk);
    #2 reset = 1'b0;
    drain();

    hit = 1'b0;
    for (int i = 0; i < 1000 && !hit; i++) begin
      @(negedge clk);
      if (ifa.pix_x == 10'd5 && ifa.pix_y == 10'd2) hit = 1'b1;
    end
    if (!hit) begin
      $display("FAIL midframe_wait actual=(%0d,%0d) required=(5,2)", ifa.pix_x, ifa.pix_y);
      $fatal(1, "mid-frame point not reached");
    end
    #2 reset = 1'b1;
    repeat (3) @(negedge clk);
    qa.delete();
    qb.delete();
    dq.delete();
    load(NA2, NB2);
    @(negedge clk);
    #2 reset = 1'b0;
    drain();

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
